// File: rtl/match_sequencer.sv
// Two-player game-flow controller: idle, 3/2/1/GO countdown, tug-of-war play, win screen.
// Owns button synchronisation/edge detection and the barrier position shown on screen.
module match_sequencer #(
  parameter int STEP_TICKS = 24_000_000,
  parameter int WIN_TICKS  = 96_000_000,
  parameter int START_POS  = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       p1_btn,
  input  logic       p2_btn,
  output logic [5:0] screen,
  output logic       in_play,
  output logic [1:0] winner
);

  localparam int MAXT = (STEP_TICKS > WIN_TICKS) ? STEP_TICKS : WIN_TICKS;
  localparam int CW   = (MAXT > 2) ? $clog2(MAXT) : 1;

  typedef enum logic [2:0] {
    IDLE, COUNT3, COUNT2, COUNT1, GO, PLAY, P1WIN, P2WIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    barrier, barrier_n, screen_n;
  logic [1:0]    winner_n;
  logic          in_play_n;

  // Bit order {start, p1, p2}; press is a one-cycle pulse per rising edge
  logic [2:0] s1, s2, prev, press;
  logic       start_p, p1_p, p2_p, step_done, win_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= {start_btn, p1_btn, p2_btn};
      s2   <= s1;
      prev <= s2;
    end
  end

  assign press   = s2 & ~prev;
  assign start_p = press[2];
  assign p1_p    = press[1];
  assign p2_p    = press[0];

  assign step_done = (cnt == CW'(STEP_TICKS - 1));
  assign win_done  = (cnt == CW'(WIN_TICKS - 1));

  always_comb begin
    state_n   = state;
    barrier_n = barrier;
    winner_n  = winner;
    cnt_n     = cnt + 1'b1;
    screen_n  = '0;
    in_play_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start_p) state_n = COUNT3;
      end
      COUNT3: if (step_done) state_n = COUNT2;
      COUNT2: if (step_done) state_n = COUNT1;
      COUNT1: if (step_done) state_n = GO;
      GO:     if (step_done) state_n = PLAY;
      PLAY: begin
        cnt_n = '0;
        // Terminal positions 30/16 go straight to the win state and are never stored
        if (p1_p && !p2_p) begin
          if (barrier == 6'd29) begin
            state_n  = P1WIN;
            winner_n = 2'b01;
          end else begin
            barrier_n = barrier + 6'd1;
          end
        end else if (p2_p && !p1_p) begin
          if (barrier == 6'd17) begin
            state_n  = P2WIN;
            winner_n = 2'b10;
          end else begin
            barrier_n = barrier - 6'd1;
          end
        end
      end
      P1WIN, P2WIN: begin
        if (start_p)       state_n = COUNT3;
        else if (win_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) cnt_n = '0;
    if (state_n == COUNT3 && state != COUNT3) begin
      winner_n  = 2'b00;
      barrier_n = 6'(START_POS);
    end

    case (state_n)
      IDLE:    screen_n = 6'd0;
      COUNT3:  screen_n = 6'd34;
      COUNT2:  screen_n = 6'd33;
      COUNT1:  screen_n = 6'd32;
      GO:      screen_n = 6'd31;
      PLAY:    screen_n = barrier_n;
      P1WIN:   screen_n = 6'd30;
      P2WIN:   screen_n = 6'd16;
      default: screen_n = 6'd0;
    endcase
    in_play_n = (state_n == PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      barrier <= 6'(START_POS);
      winner  <= 2'b00;
      screen  <= '0;
      in_play <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      barrier <= barrier_n;
      winner  <= winner_n;
      screen  <= screen_n;
      in_play <= in_play_n;
    end
  end

endmodule
